// File: rtl/press_event_arbiter.sv
// press_event_arbiter
//
// Turns N asynchronous button/switch levels into rising-edge press events and
// hands them one at a time to a single downstream consumer over a
// valid/ready handshake. Each channel has its own two-flop synchroniser,
// rising-edge detector and saturating pending-press counter. A round-robin
// arbiter picks the next channel to serve, starting just after the last one
// granted.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   signal     raw asynchronous input levels, bit i = channel i
//   evt_ready  consumer accepts the currently held event this cycle
//   ovf_clr    synchronous clear of all overflow flags
//   evt_valid  event register holds an undelivered event
//   evt_id     channel index of the held event
//   ovf        sticky per-channel flag: a press was lost to saturation
//   busy       any press still queued or an event still held

module press_event_arbiter #(
  parameter int N      = 4,
  parameter int PEND_W = 3,
  localparam int ID_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    signal,
  input  logic            evt_ready,
  input  logic            ovf_clr,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N-1:0]    ovf,
  output logic            busy
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [N-1:0]      sync1;
  logic [N-1:0]      sync2;
  logic [N-1:0]      prev;
  logic [N-1:0]      edge_det;
  logic [N-1:0]      pend_nz;
  logic [N-1:0]      grant;
  logic [PEND_W-1:0] pend [N];
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              load;

  assign edge_det = sync2 & ~prev;

  // The output register can take a new event when it is empty or its
  // current event is being accepted on this same edge (no bubble).
  assign load = ~evt_valid | evt_ready;

  assign busy = (|pend_nz) | evt_valid;

  always_comb begin
    pend_nz = '0;
    for (int i = 0; i < N; i++) begin
      pend_nz[i] = |pend[i];
    end
  end

  // Round-robin search: begin one past the last granted channel and wrap,
  // so a waiting channel is served within N accepted events.
  always_comb begin
    logic [ID_W-1:0] idx;
    found  = 1'b0;
    winner = last_grant;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((int'(last_grant) + k) % N);
      if (!found && pend_nz[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (load && found) begin
      grant[winner] = 1'b1;
    end
  end

  // Two-flop synchroniser plus a history flop for edge detection. All start
  // at 0, so an input already high when reset releases never counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= signal;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Pending counters saturate at their maximum; a press arriving while full
  // is dropped and flagged. A press and a grant on the same channel in the
  // same cycle cancel out. A new overflow beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        pend[i] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (edge_det[i] && !grant[i]) begin
          if (pend[i] != PEND_MAX) begin
            pend[i] <= pend[i] + 1'b1;
          end
        end else if (!edge_det[i] && grant[i]) begin
          pend[i] <= pend[i] - 1'b1;
        end

        if (edge_det[i] && !grant[i] && (pend[i] == PEND_MAX)) begin
          ovf[i] <= 1'b1;
        end else if (ovf_clr) begin
          ovf[i] <= 1'b0;
        end
      end
    end
  end

  // Output event register. While the consumer stalls, the held event and
  // the round-robin pointer stay frozen. evt_id keeps its last value when
  // the register empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      last_grant <= ID_W'(N - 1);
    end else if (load) begin
      if (found) begin
        evt_valid  <= 1'b1;
        evt_id     <= winner;
        last_grant <= winner;
      end else begin
        evt_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_press_event_arbiter.sv
// tb_press_event_arbiter
//
// Self-checking bench for press_event_arbiter (N=4, PEND_W=3). Expected
// event ids are queued when presses are driven and popped by a monitor each
// time the DUT hands an event over. A table of press patterns drives the
// round-robin ordering; hand-written sequences cover the first-event
// latency, backpressure, saturation, fairness and asynchronous reset.

module tb_press_event_arbiter;

  localparam int N      = 4;
  localparam int PEND_W = 3;

  typedef struct {
    logic [3:0]      press;
    int              count;
    logic [3:0][1:0] ids;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] signal = '0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] ovf;
  logic       busy;

  logic [1:0] sb [$];
  int         pass_count = 0;
  int         check_count = 0;
  int         unexpected = 0;
  bit         fair_mode = 1'b0;
  int         fair_count = 0;
  int         fair_base = 0;
  int         fair_pos = 0;
  bit         fair_seen = 1'b0;
  vec_t       vecs [9];

  press_event_arbiter #(
    .N      (N),
    .PEND_W (PEND_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .signal    (signal),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Handshakes complete on the next rising edge; sample them mid-cycle.
  always @(negedge clk) begin
    logic [1:0] exp_id;
    if (!rst && evt_valid && evt_ready) begin
      if (fair_mode) begin
        fair_count++;
        if (evt_id == 2'd2 && !fair_seen) begin
          fair_seen = 1'b1;
          fair_pos  = fair_count;
        end
      end else if (sb.size() == 0) begin
        check_count++;
        unexpected++;
        $display("[TB] FAIL unexpected_event: got id %0d, expected none", evt_id);
      end else begin
        exp_id = sb.pop_front();
        checkOutput("event_id", 32'(evt_id), 32'(exp_id));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    signal    = '0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    checkOutput("reset_valid", 32'(evt_valid), 32'd0);
    checkOutput("reset_id", 32'(evt_id), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      cyc(1);
      n++;
    end
    checkOutput({name, "_drain"}, 32'(sb.size()), 32'd0);
    checkOutput({name, "_idle"}, 32'(busy), 32'd0);
    sb.delete();
    cyc(3);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    signal = v.press;
    for (int j = 0; j < v.count; j++) begin
      sb.push_back(v.ids[j]);
    end
    cyc(4);
    signal = '0;
    waitDrain(name);
  endtask

  initial begin
    // Expected order follows round-robin from the last granted channel,
    // starting right after reset (last grant = 3).
    vecs[0] = '{press: 4'b1111, count: 4, ids: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{press: 4'b0001, count: 1, ids: {2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[2] = '{press: 4'b1111, count: 4, ids: {2'd0, 2'd3, 2'd2, 2'd1}};
    vecs[3] = '{press: 4'b0110, count: 2, ids: {2'd0, 2'd0, 2'd2, 2'd1}};
    vecs[4] = '{press: 4'b1001, count: 2, ids: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[5] = '{press: 4'b1010, count: 2, ids: {2'd0, 2'd0, 2'd3, 2'd1}};
    vecs[6] = '{press: 4'b0101, count: 2, ids: {2'd0, 2'd0, 2'd2, 2'd0}};
    vecs[7] = '{press: 4'b1011, count: 3, ids: {2'd0, 2'd1, 2'd0, 2'd3}};
    vecs[8] = '{press: 4'b0100, count: 1, ids: {2'd0, 2'd0, 2'd0, 2'd2}};

    // Single press: event appears 3 edges after the first sample, 1 cycle.
    doReset();
    evt_ready = 1'b1;
    signal    = 4'b0001;
    sb.push_back(2'd0);
    cyc(1);
    checkOutput("single_lat1", 32'(evt_valid), 32'd0);
    cyc(1);
    checkOutput("single_lat2", 32'(evt_valid), 32'd0);
    cyc(1);
    checkOutput("single_lat3", 32'(evt_valid), 32'd0);
    checkOutput("single_busy", 32'(busy), 32'd1);
    cyc(1);
    checkOutput("single_valid", 32'(evt_valid), 32'd1);
    checkOutput("single_id", 32'(evt_id), 32'd0);
    cyc(1);
    checkOutput("single_once", 32'(evt_valid), 32'd0);
    cyc(5);
    signal = '0;
    waitDrain("single");

    // Round-robin ordering table.
    doReset();
    evt_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v], $sformatf("vec%0d", v));
    end

    // Backpressure: held event is stable while the consumer stalls.
    doReset();
    signal = 4'b0110;
    sb.push_back(2'd1);
    sb.push_back(2'd2);
    cyc(4);
    signal = '0;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_hold_valid", 32'(evt_valid), 32'd1);
      checkOutput("bp_hold_id", 32'(evt_id), 32'd1);
      cyc(1);
    end
    evt_ready = 1'b1;
    cyc(1);
    checkOutput("bp_next_valid", 32'(evt_valid), 32'd1);
    checkOutput("bp_next_id", 32'(evt_id), 32'd2);
    cyc(1);
    checkOutput("bp_empty", 32'(evt_valid), 32'd0);
    waitDrain("bp");

    // Saturation: 9 presses while stalled -> 1 held + 7 queued, 1 lost.
    evt_ready = 1'b0;
    for (int p = 0; p < 9; p++) begin
      if (p < 8) sb.push_back(2'd3);
      signal = 4'b1000;
      cyc(2);
      signal = '0;
      cyc(2);
    end
    cyc(4);
    checkOutput("sat_ovf", 32'(ovf), 32'h8);
    checkOutput("sat_valid", 32'(evt_valid), 32'd1);
    checkOutput("sat_id", 32'(evt_id), 32'd3);
    checkOutput("sat_busy", 32'(busy), 32'd1);
    evt_ready = 1'b1;
    waitDrain("sat");
    checkOutput("sat_ovf_sticky", 32'(ovf), 32'h8);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    checkOutput("sat_ovf_clr", 32'(ovf), 32'd0);

    // Fairness: channel 2 is served promptly despite a busy channel 0.
    fair_mode  = 1'b1;
    fair_count = 0;
    fair_seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      signal[0] = (i % 2 == 1) ? 1'b1 : 1'b0;
      if (i == 6) begin
        fair_base = fair_count;
        signal[2] = 1'b1;
      end
      cyc(1);
    end
    signal = '0;
    waitDrain("fair");
    fair_mode = 1'b0;
    checkOutput("fair_seen", 32'(fair_seen), 32'd1);
    checkOutput("fair_within_n", 32'((fair_pos - fair_base) <= N), 32'd1);

    // Asynchronous reset with work queued, an event held and an overflow.
    evt_ready = 1'b0;
    signal    = 4'b1111;
    cyc(3);
    signal = '0;
    cyc(2);
    for (int p = 0; p < 8; p++) begin
      signal = 4'b0010;
      cyc(2);
      signal = '0;
      cyc(2);
    end
    cyc(4);
    checkOutput("ar_pre_ovf", 32'(ovf), 32'h2);
    checkOutput("ar_pre_valid", 32'(evt_valid), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", 32'(evt_valid), 32'd0);
    checkOutput("ar_busy", 32'(busy), 32'd0);
    checkOutput("ar_ovf", 32'(ovf), 32'd0);
    checkOutput("ar_id", 32'(evt_id), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    evt_ready = 1'b1;
    cyc(20);
    checkOutput("ar_no_spurious", 32'(unexpected), 32'd0);
    checkOutput("ar_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
